// File: rtl/gcd_stein.sv
// Binary (Stein) GCD with start/done handshake, one shift/subtract step per cycle.
// Define GCD_CYCLES_EN to add the saturating 16-bit `cycles` latency output.
module gcd_stein #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [WIDTH-1:0] opa,
  input  logic [WIDTH-1:0] opb,
  input  logic             start,
  output logic [WIDTH-1:0] result,
  output logic             done,
  output logic             busy
`ifdef GCD_CYCLES_EN
  ,
  output logic [15:0]      cycles
`endif
);

  localparam int unsigned KW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, SHIFT, REDUCE} state_t;

  state_t          state, state_nx;
  logic [WIDTH-1:0] a, b, a_nx, b_nx;
  logic [KW-1:0]    k, k_nx;
  logic             finish;

  always_comb begin
    state_nx = state;
    a_nx     = a;
    b_nx     = b;
    k_nx     = k;
    finish   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          k_nx = '0;
          // A zero operand loads a==b==opa|opb so REDUCE finishes on the very next edge.
          if (opa == '0 || opb == '0) begin
            a_nx     = opa | opb;
            b_nx     = opa | opb;
            state_nx = REDUCE;
          end else begin
            a_nx     = opa;
            b_nx     = opb;
            state_nx = SHIFT;
          end
        end
      end
      SHIFT: begin
        if (!a[0] && !b[0]) begin
          a_nx = a >> 1;
          b_nx = b >> 1;
          k_nx = k + KW'(1);
        end else begin
          state_nx = REDUCE;
        end
      end
      REDUCE: begin
        if (a == b) begin
          finish   = 1'b1;
          state_nx = IDLE;
        end else if (!a[0]) begin
          a_nx = a >> 1;
        end else if (!b[0]) begin
          b_nx = b >> 1;
        end else if (a > b) begin
          a_nx = (a - b) >> 1;
        end else begin
          b_nx = (b - a) >> 1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state  <= IDLE;
      a      <= '0;
      b      <= '0;
      k      <= '0;
      result <= '0;
      done   <= 1'b0;
    end else begin
      state <= state_nx;
      a     <= a_nx;
      b     <= b_nx;
      k     <= k_nx;
      done  <= finish;
      if (finish) result <= a << k;
    end
  end

  assign busy = (state != IDLE);

`ifdef GCD_CYCLES_EN
  logic [15:0] cnt, cnt_inc;

  assign cnt_inc = (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      cnt    <= '0;
      cycles <= '0;
    end else begin
      if (state == IDLE) cnt <= '0;
      else               cnt <= cnt_inc;
      if (finish) cycles <= cnt_inc;
    end
  end
`endif

endmodule

// File: doc/gcd_stein.md
# gcd_stein

Parametrised successor to the team's 32-bit subtractive GCD block. It computes the greatest common divisor of two unsigned WIDTH-bit operands using the binary (Stein) algorithm: strip common factors of two, reduce with one shift/subtract per cycle, then restore the factor. It sits behind a start/done handshake on the single core clock and adds behaviour the earlier block lacks: a WIDTH parameter, explicit zero-operand handling, a busy flag, and an optional cycle counter.

## Interface
- WIDTH, 32: operand and result width in bits; must be at least 2.
- clk  in  1  core clock; all state updates on the rising edge.
- resetn  in  1  reset; synchronous, active-low.
- opa  in  WIDTH  operand A, unsigned; sampled only on an accepting edge.
- opb  in  WIDTH  operand B, unsigned; sampled only on an accepting edge.
- start  in  1  request; an accepting edge is a rising edge with start=1 while the block is idle.
- result  out  WIDTH  GCD of the last completed operation; holds until the next completion.
- done  out  1  one-cycle pulse; result is valid in the same cycle.
- busy  out  1  high from the accepting edge until the completing edge.
- cycles  out  16  present only with GCD_CYCLES_EN; see Configuration.

## Operation
- States: IDLE, SHIFT, REDUCE. Internal registers: a, b (WIDTH bits); k, the common power-of-two count ($clog2(WIDTH)+1 bits).
- IDLE, start=1: capture a=opa, b=opb, k=0, busy=1.
  - If opa=0 or opb=0: on the next edge, result=opa|opb, done=1, return to IDLE. Both zero gives result 0.
  - Otherwise go to SHIFT.
- SHIFT, per edge:
  - If a and b are both even: a>>=1, b>>=1, k+=1.
  - Else: move to REDUCE with no data change.
- REDUCE, per edge, first matching rule wins:
  - a==b: result=a<<k, done=1, busy=0, return to IDLE.
  - a even: a>>=1.
  - b even: b>>=1.
  - a>b: a=(a-b)>>1.
  - Otherwise: b=(b-a)>>1.
- Arithmetic: subtraction is always of the smaller from the larger, so there is no borrow. a<<k never exceeds max(opa,opb) and so never overflows WIDTH.
- start during SHIFT or REDUCE is ignored; operands are not re-sampled.
- start=1 in the done cycle (the block is already IDLE) is accepted. done drops on that edge. result keeps the previous value until the new completion.

## Timing
- Reset (resetn=0 at a rising edge): state=IDLE, result=0, done=0, busy=0, cycles=0.
- Reset mid-operation aborts the operation with no done pulse and no result update.
- Zero operand: accept at edge N; done high after edge N+1.
- General case: done high after edge N+1+s+r.
  - s = number of common trailing zeros.
  - r = number of REDUCE edges, including the terminating one.
- Example: opa=102, opb=12 gives s=1, r=6, so done after N+8.
- busy is high after edge N through the cycle before done. busy and done are never high together.
- done is high for exactly one cycle.

## Configuration
- GCD_CYCLES_EN defined:
  - cycles port exists. It is a 16-bit count of edges from acceptance to completion (1+s+r; 1 for a zero operand).
  - It saturates at 16'hFFFF, updates with result, and otherwise holds.
- GCD_CYCLES_EN undefined: the port and counter are absent. All other behaviour and timing are identical.

## Test plan
- resetn=0 for 3 edges, then release: result=0, done=0, busy=0, cycles=0. Start (102,12) and assert resetn=0 after 3 edges: no done pulse, result stays 0.
- WIDTH=32, start (102,12): done after accept+8, result=6, cycles=8. Then (18190,13082) gives 2, (82066,36915) gives 1, (68490,78579) gives 9.
- Zero operands: (0,45) gives result 45 one edge after accept; (45,0) gives 45; (0,0) gives 0. Each has cycles=1.
- Start held at 1 across completion: (34456,36928) gives 8. The next operation, (76156,1924), is accepted in the done cycle and gives 4. Changing opa while busy does not alter the result.
- WIDTH=8, (255,255) gives 255 and (128,192) gives 64 with no overflow. A random sweep of 1000 pairs is checked against a reference GCD model.
- Build without GCD_CYCLES_EN: the same vectors give identical result and done timing.
